ifmap_window_reader: RTL and testbench
======================================

Name: ifmap_window_reader

Overview:
- Read-side address generator for the circular IFMap scratchpad. It is the consumer end of the buffer whose write side is gated by the IFMap write/length control.
- Walks a 1-D filter window across the current row held in the buffer. Emits one read pointer per element, with a valid/ready handshake to the PE datapath.
- Advances the window by the stride after each window (co_filter pulse).
- At row end, signals end_row and then next_row, so the length counter releases the row and the next row start is loaded.

Parameters:
- POINTER_SIZE, 8, width of buffer pointers, lengths and filter size.
- STRIDE_SIZE, 3, width of the stride input.
- IFMAP_SIZE, 16, buffer depth in elements. Need not be a power of two.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin processing one row; sampled only in IDLE.
- row_len  input  POINTER_SIZE  element count of the row; sampled at start.
- filter_size  input  POINTER_SIZE  window length; sampled at start.
- stride  input  STRIDE_SIZE  window step; sampled at start; 0 is treated as 1.
- len_counter  input  POINTER_SIZE  valid elements in the buffer, counted from the current row start.
- rd_ready  input  1  PE accepts the current element.
- read_pointer  output  POINTER_SIZE  buffer address of the current element.
- rd_valid  output  1  read_pointer refers to valid data.
- last_in_window  output  1  current element is the final element of its window.
- co_filter  output  1  one-cycle pulse when a window completes; drives stride_en.
- end_row  output  1  one-cycle pulse when the row's last window is done.
- next_row  output  1  one-cycle pulse, one cycle after end_row; drives dec_len/ld_start_row.
- busy  output  1  high in any state other than IDLE.
- cfg_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Registers:
  - row_start (POINTER_SIZE): persists across rows.
  - win_off: window start offset within the row.
  - k: element index within the window.
  - Latched copies of row_len, filter_size and stride.
- Reset: state=IDLE; row_start, win_off and k = 0; all outputs 0. rst mid-row aborts immediately. No end_row or next_row is emitted.
- Address computation:
  - sum = row_start + win_off + k, computed at POINTER_SIZE+1 bits.
  - read_pointer = sum - IFMAP_SIZE if sum >= IFMAP_SIZE, else sum. One subtraction suffices because row_start < IFMAP_SIZE and win_off+k < row_len <= IFMAP_SIZE.
- IDLE:
  - A start with filter_size==0 or filter_size>row_len is rejected. cfg_err pulses the next cycle and the block stays in IDLE.
  - Any other start latches the config, clears win_off and k, and moves to READ the next cycle.
  - start is ignored in all other states.
- READ:
  - rd_valid = (win_off+k < len_counter), evaluated combinationally every cycle. While it is low the block stalls (data not yet written).
  - last_in_window = (k == filter_size-1), qualified by the READ state.
  - On rd_valid && rd_ready: if last_in_window then k=0 and go to STRIDE; otherwise k++.
  - read_pointer, rd_valid and last_in_window are held stable while rd_valid && !rd_ready.
- STRIDE (1 cycle):
  - co_filter=1.
  - If win_off + stride + filter_size > row_len, go to ROW_END and leave win_off unchanged.
  - Otherwise win_off += stride and go to READ.
- ROW_END (1 cycle): end_row=1; go to RELEASE.
- RELEASE (1 cycle):
  - next_row=1.
  - row_start = (row_start + row_len) mod IFMAP_SIZE, using the same single-subtract wrap.
  - Clear win_off; go to IDLE.
- rd_valid is 0 outside READ.
- Throughput: 1 element/cycle when unstalled, plus 3 overhead cycles per window boundary/row end (STRIDE, and ROW_END+RELEASE at row end).
- Output timing: co_filter, end_row, next_row and cfg_err are registered state decodes. They are never asserted together.

Decomposition:
- Shared package ifmap_pkg holds:
  - state enum (IDLE, READ, STRIDE, ROW_END, RELEASE);
  - a ptr_t typedef of POINTER_SIZE bits;
  - a wrap-add function used by both the read_pointer and row_start updates.
- One sub-module is natural: circ_ptr_add, a combinational modulo-IFMAP_SIZE adder instantiated twice. The FSM and counters stay in the top.

Test Plan:
- Basic row (IFMAP_SIZE=16): row_len=5, filter=3, stride=1, len_counter=5, rd_ready=1.
  - read_pointer sequence must be 0,1,2,1,2,3,2,3,4.
  - Exactly 3 co_filter pulses, then end_row, then next_row.
  - Final row_start=5.
- Stride 2: row_len=7, filter=3, stride=2.
  - Windows start at 0, 2 and 4.
  - 9 reads, 3 co_filter pulses, row ends after the window at 4.
- Wrap-around: row_start=14 (reached via prior rows), row_len=4, filter=4, stride=2.
  - Reads must be 14, 15, 0, 1.
  - 1 co_filter pulse; new row_start=2.
- Data stall and backpressure:
  - len_counter=1 at start: rd_valid drops at offset 1 and rises when len_counter becomes 2.
  - rd_ready low for 3 cycles mid-window: read_pointer is held; no element is skipped or duplicated.
- Config error: start with filter_size=6, row_len=5 → cfg_err pulse, busy stays 0, no reads are issued.
- Reset mid-row: assert rst during the second window.
  - All outputs are 0 the next cycle; no end_row or next_row pulse.
  - A new start reads from address 0.

Source files
------------

// File: rtl/ifmap_pkg.sv
// Shared types and helpers for the IFMap window reader: FSM states, pointer type
// and the single-subtract circular add used for every buffer address.
package ifmap_pkg;

    localparam int PTR_W = 8;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        STRIDE,
        ROW_END,
        RELEASE
    } state_e;

    // Both operands are below depth, so one conditional subtract is a full modulo.
    function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] depth);
        logic [31:0] s;
        s = a + b;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/circ_ptr_add.sv
// Combinational modulo-DEPTH adder for circular scratchpad pointers.
module circ_ptr_add
    import ifmap_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = W'(wrap_add(32'(a_i), 32'(b_i), 32'(DEPTH)));

endmodule

// File: rtl/ifmap_window_reader.sv
// Read-side address generator for the circular IFMap scratchpad: walks a 1-D
// filter window across the current row and hands one pointer per element to the PE.
module ifmap_window_reader
    import ifmap_pkg::*;
#(
    parameter int POINTER_SIZE = 8,
    parameter int STRIDE_SIZE  = 3,
    parameter int IFMAP_SIZE   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [POINTER_SIZE-1:0] row_len,
    input  logic [POINTER_SIZE-1:0] filter_size,
    input  logic [STRIDE_SIZE-1:0]  stride,
    input  logic [POINTER_SIZE-1:0] len_counter,
    input  logic                    rd_ready,
    output logic [POINTER_SIZE-1:0] read_pointer,
    output logic                    rd_valid,
    output logic                    last_in_window,
    output logic                    co_filter,
    output logic                    end_row,
    output logic                    next_row,
    output logic                    busy,
    output logic                    cfg_err
);

    localparam int W = POINTER_SIZE;

    state_e                 state_q;
    logic [W-1:0]           row_start_q;
    logic [W-1:0]           win_off_q;
    logic [W-1:0]           k_q;
    logic [W-1:0]           row_len_q;
    logic [W-1:0]           filter_q;
    logic [STRIDE_SIZE-1:0] stride_q;
    logic                   co_filter_q;
    logic                   end_row_q;
    logic                   next_row_q;
    logic                   cfg_err_q;

    logic [W-1:0]           elem_off;
    logic [W-1:0]           row_start_nxt;
    logic [W+1:0]           next_win_end;
    logic                   cfg_bad;
    logic                   handshake;

    assign elem_off = win_off_q + k_q;

    circ_ptr_add #(.W(W), .DEPTH(IFMAP_SIZE)) u_rd_addr (
        .a_i   (row_start_q),
        .b_i   (elem_off),
        .sum_o (read_pointer)
    );

    circ_ptr_add #(.W(W), .DEPTH(IFMAP_SIZE)) u_row_addr (
        .a_i   (row_start_q),
        .b_i   (row_len_q),
        .sum_o (row_start_nxt)
    );

    // End of the window that would follow a stride; past row_len means the row is done.
    assign next_win_end = {2'b00, win_off_q}
                        + {{(W+2-STRIDE_SIZE){1'b0}}, stride_q}
                        + {2'b00, filter_q};

    assign cfg_bad        = (filter_size == '0) || (filter_size > row_len);
    assign rd_valid       = (state_q == READ) && (elem_off < len_counter);
    assign last_in_window = (state_q == READ) && (k_q == filter_q - W'(1));
    assign handshake      = rd_valid && rd_ready;

    assign co_filter = co_filter_q;
    assign end_row   = end_row_q;
    assign next_row  = next_row_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != IDLE);

    // NOTE: every register here uses <= so all branches see pre-edge values and
    // the pulse flags can be cleared up front and re-set by the taken branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_start_q <= '0;
            win_off_q   <= '0;
            k_q         <= '0;
            row_len_q   <= '0;
            filter_q    <= '0;
            stride_q    <= '0;
            co_filter_q <= 1'b0;
            end_row_q   <= 1'b0;
            next_row_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            co_filter_q <= 1'b0;
            end_row_q   <= 1'b0;
            next_row_q  <= 1'b0;
            cfg_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            row_len_q <= row_len;
                            filter_q  <= filter_size;
                            stride_q  <= (stride == '0) ? STRIDE_SIZE'(1) : stride;
                            win_off_q <= '0;
                            k_q       <= '0;
                            state_q   <= READ;
                        end
                    end
                end

                READ: begin
                    if (handshake) begin
                        if (last_in_window) begin
                            k_q         <= '0;
                            co_filter_q <= 1'b1;
                            state_q     <= STRIDE;
                        end else begin
                            k_q <= k_q + W'(1);
                        end
                    end
                end

                STRIDE: begin
                    if (next_win_end > {2'b00, row_len_q}) begin
                        end_row_q <= 1'b1;
                        state_q   <= ROW_END;
                    end else begin
                        win_off_q <= win_off_q + W'(stride_q);
                        state_q   <= READ;
                    end
                end

                ROW_END: begin
                    next_row_q <= 1'b1;
                    state_q    <= RELEASE;
                end

                RELEASE: begin
                    row_start_q <= row_start_nxt;
                    win_off_q   <= '0;
                    state_q     <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_window_reader.sv
// Self-checking bench: an event-queue model of each row is compared every cycle
// against the DUT, with directed rows pinned by literal pointer sequences.
module tb_ifmap_window_reader;

    localparam int PW    = 8;
    localparam int SW    = 3;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] row_len = '0;
    logic [PW-1:0] filter_size = '0;
    logic [SW-1:0] stride = '0;
    logic [PW-1:0] len_counter = '0;
    logic          rd_ready = 1'b0;
    logic [PW-1:0] read_pointer;
    logic          rd_valid, last_in_window, co_filter, end_row, next_row, busy, cfg_err;

    ifmap_window_reader #(.POINTER_SIZE(PW), .STRIDE_SIZE(SW), .IFMAP_SIZE(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .filter_size(filter_size),
        .stride(stride), .len_counter(len_counter), .rd_ready(rd_ready),
        .read_pointer(read_pointer), .rd_valid(rd_valid), .last_in_window(last_in_window),
        .co_filter(co_filter), .end_row(end_row), .next_row(next_row), .busy(busy),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted row expands into the ordered list of events it must produce.
    typedef enum {EV_READ, EV_CO, EV_END, EV_NEXT} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       off;
        bit       last;
    } ev_t;

    ev_t exp_q[$];
    bit  reading    = 1'b0;
    bit  cfg_pend   = 1'b0;
    bit  model_idle = 1'b1;
    int  m_row_start = 0;
    int  m_row_len   = 0;
    int  obs_ptrs[$];
    int  exp_ptrs[$];
    int  co_cnt = 0, end_cnt = 0, next_cnt = 0;

    function automatic void push_row(input int rl, input int fs, input int st);
        int s;
        s = (st == 0) ? 1 : st;
        for (int off = 0; off + fs <= rl; off += s) begin
            for (int k = 0; k < fs; k++) exp_q.push_back('{EV_READ, off + k, k == fs - 1});
            exp_q.push_back('{EV_CO, 0, 1'b0});
            if (off + s + fs > rl) break;
        end
        exp_q.push_back('{EV_END, 0, 1'b0});
        exp_q.push_back('{EV_NEXT, 0, 1'b0});
    endfunction

    always @(negedge clk) begin
        ev_t h;
        if (rst) begin
            exp_q.delete();
            reading     = 1'b0;
            cfg_pend    = 1'b0;
            m_row_start = 0;
            model_idle  = 1'b1;
        end else begin
            co_cnt   += int'(co_filter);
            end_cnt  += int'(end_row);
            next_cnt += int'(next_row);
            check("busy", busy, exp_q.size() != 0);
            check("cfg_err", cfg_err, cfg_pend);
            cfg_pend = 1'b0;
            if (reading) begin
                h = exp_q[0];
                check("rd_valid", rd_valid, h.off < int'(len_counter));
                check("read_pointer", read_pointer, (m_row_start + h.off) % DEPTH);
                check("last_in_window", last_in_window, h.last);
                check("co_filter_in_read", co_filter, 0);
                check("end_row_in_read", end_row, 0);
                check("next_row_in_read", next_row, 0);
                if (rd_valid && rd_ready) begin
                    obs_ptrs.push_back(int'(read_pointer));
                    void'(exp_q.pop_front());
                    if (h.last) reading = 1'b0;
                end
            end else if (exp_q.size() != 0) begin
                h = exp_q.pop_front();
                check("rd_valid_pulse", rd_valid, 0);
                check("last_pulse", last_in_window, 0);
                check("co_filter", co_filter, h.kind == EV_CO);
                check("end_row", end_row, h.kind == EV_END);
                check("next_row", next_row, h.kind == EV_NEXT);
                if (h.kind == EV_CO && exp_q.size() != 0 && exp_q[0].kind == EV_READ) reading = 1'b1;
                if (h.kind == EV_NEXT) m_row_start = (m_row_start + m_row_len) % DEPTH;
            end else begin
                check("rd_valid_idle", rd_valid, 0);
                check("last_idle", last_in_window, 0);
                check("pulses_idle", {co_filter, end_row, next_row}, 0);
                if (start) begin
                    if (filter_size == 0 || filter_size > row_len) begin
                        cfg_pend = 1'b1;
                    end else begin
                        m_row_len = int'(row_len);
                        push_row(int'(row_len), int'(filter_size), int'(stride));
                        reading = 1'b1;
                    end
                end
            end
            model_idle = (exp_q.size() == 0) && !cfg_pend;
        end
    end

    bit rand_mode = 1'b0;
    int lc_max    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            rd_ready = ($urandom_range(3) != 0);
            if (int'(len_counter) < lc_max && $urandom_range(2) == 0) len_counter = len_counter + 1'b1;
        end
    endtask

    task automatic start_row(input int rl, input int fs, input int st, input int lc);
        row_len     = PW'(rl);
        filter_size = PW'(fs);
        stride      = SW'(st);
        len_counter = PW'(lc);
        lc_max      = rl;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!model_idle && n < budget) begin
            tick();
            n++;
        end
        if (!model_idle) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic check_ptrs(input string name, input int base);
        check({name, "_count"}, obs_ptrs.size() - base, exp_ptrs.size());
        for (int i = 0; i < exp_ptrs.size() && base + i < obs_ptrs.size(); i++)
            check(name, obs_ptrs[base + i], exp_ptrs[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, bc, be, bn, n;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ptr", read_pointer, 0);
        check("reset_outputs", {rd_valid, last_in_window, co_filter, end_row, next_row, busy, cfg_err}, 0);

        // Basic row
        rd_ready = 1'b1;
        b = obs_ptrs.size(); bc = co_cnt; be = end_cnt; bn = next_cnt;
        start_row(5, 3, 1, 5);
        wait_idle("basic", 200);
        exp_ptrs = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        check_ptrs("basic_ptrs", b);
        check("basic_co", co_cnt - bc, 3);
        check("basic_end", end_cnt - be, 1);
        check("basic_next", next_cnt - bn, 1);

        // Stride 2, starts at row_start 5
        b = obs_ptrs.size(); bc = co_cnt;
        start_row(7, 3, 2, 7);
        wait_idle("stride2", 200);
        exp_ptrs = '{5, 6, 7, 7, 8, 9, 9, 10, 11};
        check_ptrs("stride2_ptrs", b);
        check("stride2_co", co_cnt - bc, 3);

        // Filler row to bring row_start to 14
        b = obs_ptrs.size();
        start_row(2, 2, 1, 2);
        wait_idle("filler", 200);
        exp_ptrs = '{12, 13};
        check_ptrs("filler_ptrs", b);

        // Wrap-around
        b = obs_ptrs.size(); bc = co_cnt;
        start_row(4, 4, 2, 4);
        wait_idle("wrap", 200);
        exp_ptrs = '{14, 15, 0, 1};
        check_ptrs("wrap_ptrs", b);
        check("wrap_co", co_cnt - bc, 1);

        // Data stall then backpressure, row_start is now 2
        b = obs_ptrs.size();
        start_row(3, 3, 1, 1);
        tick();
        @(negedge clk);
        check("stall_low", rd_valid, 0);
        len_counter = 2;
        #1;
        check("stall_rise", rd_valid, 1);
        tick();
        len_counter = 3;
        rd_ready    = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("bp_valid", rd_valid, 1);
        check("bp_hold_ptr", read_pointer, 4);
        rd_ready = 1'b1;
        wait_idle("stall", 200);
        exp_ptrs = '{2, 3, 4};
        check_ptrs("stall_ptrs", b);

        // Config error
        b = obs_ptrs.size();
        start_row(5, 6, 1, 5);
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        wait_idle("cfg", 20);
        check("cfg_no_reads", obs_ptrs.size() - b, 0);

        // Reset during the second window
        bc = co_cnt; be = end_cnt; bn = next_cnt;
        start_row(6, 3, 1, 6);
        n = 0;
        while (co_cnt - bc < 1 && n < 100) begin tick(); n++; end
        check("rst_reached_window2", co_cnt - bc, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ptr", read_pointer, 0);
        check("rst_outputs", {rd_valid, last_in_window, co_filter, end_row, next_row, busy, cfg_err}, 0);
        check("rst_no_end", end_cnt - be, 0);
        check("rst_no_next", next_cnt - bn, 0);
        b = obs_ptrs.size();
        start_row(3, 3, 1, 3);
        wait_idle("after_rst", 200);
        exp_ptrs = '{0, 1, 2};
        check_ptrs("after_rst_ptrs", b);

        // Randomized rows with random data arrival and backpressure
        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int rl, fs, st, lc;
            rl = 1 + $urandom_range(DEPTH - 1);
            fs = $urandom_range(rl + 1);
            st = $urandom_range(7);
            lc = $urandom_range(rl);
            start_row(rl, fs, st, lc);
            wait_idle("random_row", 2000);
        end
        rand_mode = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
